// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR result buffer.
// Code width, FIFO depth, averaging factor and the capture-state enum.
package sar_pkg;
  localparam int CODE_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int AVG_N      = 4;
  localparam int LEVEL_W    = 3;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int ACC_W      = 6;
  localparam int CNT_W      = $clog2(AVG_N);

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cap_state_t;
endpackage

// File: rtl/sar_code_fifo.sv
// 4-deep code FIFO with wrapping pointers, occupancy and overflow detect.
// A full FIFO still accepts a push when a pop happens on the same edge.
module sar_code_fifo
  import sar_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               push,
  input  code_t              din,
  input  logic               pop,
  output code_t              dout,
  output logic               dvalid,
  output logic [LEVEL_W-1:0] level,
  output logic               ovf_evt
);
  code_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == LEVEL_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)
        level <= level + LEVEL_W'(1);
      else if (do_pop && !do_push)
        level <= level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Storage is not reset; an empty FIFO masks the head to zero.
  assign dout   = empty ? '0 : mem[rd_ptr];
  assign dvalid = !empty;
endmodule

// File: rtl/sar_result_buffer.sv
// SAR result capture FSM feeding a 4-deep FIFO with sticky overflow.
// Define SAR_AVG_EN to push the average of every 4 captures instead.
module sar_result_buffer
  import sar_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               SAR_RESET,
  input  logic [2:0]         BITS,
  input  logic               LSBIN,
  output logic [CODE_W-1:0]  DOUT,
  output logic               DVALID,
  input  logic               DREADY,
  output logic               OVF,
  input  logic               OVF_CLR,
  output logic [LEVEL_W-1:0] LEVEL
);
  cap_state_t state;
  logic       capture;
  code_t      code;
  logic       push;
  code_t      push_code;
  logic       ovf_evt;

  assign capture = (state == ARMED) && SAR_RESET;
  assign code    = {BITS, LSBIN};

  // Arm only after a low strobe, so a held or reset-aligned strobe is skipped.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!SAR_RESET) state <= ARMED;
        ARMED:   if (SAR_RESET)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAR_AVG_EN
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;

  assign acc_sum   = acc + ACC_W'(code);
  assign push      = capture && (cnt == CNT_W'(AVG_N - 1));
  assign push_code = code_t'(acc_sum >> CNT_W);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      acc <= '0;
      cnt <= '0;
    end else if (capture) begin
      if (push) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  assign push      = capture;
  assign push_code = code;
`endif

  sar_code_fifo u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .din     (push_code),
    .pop     (DVALID && DREADY),
    .dout    (DOUT),
    .dvalid  (DVALID),
    .level   (LEVEL),
    .ovf_evt (ovf_evt)
  );

  // Set wins over clear when both land on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      OVF <= 1'b0;
    else if (ovf_evt)
      OVF <= 1'b1;
    else if (OVF_CLR)
      OVF <= 1'b0;
  end
endmodule

// File: tb/tb_sar_result_buffer.sv
// Directed and randomized bench for sar_result_buffer.
// Reference: strobe rising-edge capture into a queue of at most 4 codes.
module tb_sar_result_buffer;
  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       SAR_RESET;
  logic [2:0] BITS;
  logic       LSBIN;
  logic [3:0] DOUT;
  logic       DVALID;
  logic       DREADY;
  logic       OVF;
  logic       OVF_CLR;
  logic [2:0] LEVEL;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sar_result_buffer dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SAR_RESET (SAR_RESET),
    .BITS      (BITS),
    .LSBIN     (LSBIN),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .DREADY    (DREADY),
    .OVF       (OVF),
    .OVF_CLR   (OVF_CLR),
    .LEVEL     (LEVEL)
  );

  int m_q[$];
  bit m_prev_low;
  bit m_ovf;
`ifdef SAR_AVG_EN
  int m_sum;
  int m_n;
`endif

  task automatic model_update();
    if (!RESET_N) begin
      m_q.delete();
      m_prev_low = 1'b0;
      m_ovf      = 1'b0;
`ifdef SAR_AVG_EN
      m_sum = 0;
      m_n   = 0;
`endif
    end else begin
      bit cap;
      bit has_push;
      bit pop;
      bit drop;
      int val;
      int code;
      code       = {BITS, LSBIN};
      cap        = m_prev_low && SAR_RESET;
      m_prev_low = !SAR_RESET;
      has_push   = 1'b0;
      val        = 0;
      if (cap) begin
`ifdef SAR_AVG_EN
        m_sum += code;
        m_n++;
        if (m_n == 4) begin
          has_push = 1'b1;
          val      = (m_sum / 4) % 16;
          m_sum    = 0;
          m_n      = 0;
        end
`else
        has_push = 1'b1;
        val      = code;
`endif
      end
      pop  = (m_q.size() > 0) && DREADY;
      drop = has_push && (m_q.size() == 4) && !pop;
      if (pop) void'(m_q.pop_front());
      if (has_push && !drop) m_q.push_back(val);
      if (drop) m_ovf = 1'b1;
      else if (OVF_CLR) m_ovf = 1'b0;
    end
  endtask

  task automatic step(input logic sr, input logic [3:0] code,
                      input logic rdy, input logic clr);
    SAR_RESET = sr;
    BITS      = code[3:1];
    LSBIN     = code[0];
    DREADY    = rdy;
    OVF_CLR   = clr;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic frame(input logic [3:0] code, input logic rdy_cap,
                       input logic rdy_rest, input logic clr_cap);
    step(1'b1, code, rdy_cap, clr_cap);
    repeat (4) step(1'b0, 4'd0, rdy_rest, 1'b0);
  endtask

  // Reset, then release so the next frame's strobe is the ignored one.
  task automatic reset_sync();
    RESET_N = 1'b0;
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b0);
    RESET_N = 1'b1;
    frame(4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) step(1'b1, 4'hF, 1'b1, 1'b0);
    checks++;
    if (LEVEL !== 3'd0) begin
      failures++; $display("FAIL reset_level got=%0d exp=0", LEVEL);
    end
    checks++;
    if (DVALID !== 1'b0) begin
      failures++; $display("FAIL reset_dvalid got=%b exp=0", DVALID);
    end
    checks++;
    if (DOUT !== 4'd0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", DOUT);
    end
    checks++;
    if (OVF !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b exp=0", OVF);
    end
    RESET_N = 1'b1;
  endtask

`ifndef SAR_AVG_EN
  task automatic test_first_frame();
    RESET_N = 1'b0;
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b0);
    RESET_N = 1'b1;
    frame(4'b1011, 1'b0, 1'b0, 1'b0);
    checks++;
    if (DVALID !== 1'b0) begin
      failures++; $display("FAIL first_ignored dvalid got=%b exp=0", DVALID);
    end
    step(1'b1, 4'b1011, 1'b0, 1'b0);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 4'b1011) begin
      failures++;
      $display("FAIL first_capture got=%b/%h exp=1/b", DVALID, DOUT);
    end
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd1) begin
      failures++; $display("FAIL first_level got=%0d exp=1", LEVEL);
    end
  endtask

  task automatic test_overflow();
    reset_sync();
    for (int i = 1; i <= 5; i++) frame(4'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd4 || OVF !== 1'b1) begin
      failures++;
      $display("FAIL ovf_fill got=%0d/%b exp=4/1", LEVEL, OVF);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (DVALID !== 1'b1 || DOUT !== 4'(i)) begin
        failures++;
        $display("FAIL ovf_drain got=%b/%0d exp=1/%0d", DVALID, DOUT, i);
      end
      step(1'b0, 4'd0, 1'b1, 1'b0);
    end
    checks++;
    if (DVALID !== 1'b0 || DOUT !== 4'd0) begin
      failures++;
      $display("FAIL ovf_empty got=%b/%h exp=0/0", DVALID, DOUT);
    end
  endtask

  task automatic test_full_pushpop();
    reset_sync();
    for (int i = 5; i <= 8; i++) frame(4'(i), 1'b0, 1'b0, 1'b0);
    frame(4'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd4 || OVF !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop got=%0d/%b exp=4/0", LEVEL, OVF);
    end
    for (int i = 6; i <= 9; i++) begin
      checks++;
      if (DVALID !== 1'b1 || DOUT !== 4'(i)) begin
        failures++;
        $display("FAIL full_drain got=%b/%0d exp=1/%0d", DVALID, DOUT, i);
      end
      step(1'b0, 4'd0, 1'b1, 1'b0);
    end
    checks++;
    if (DVALID !== 1'b0) begin
      failures++; $display("FAIL full_empty got=%b exp=0", DVALID);
    end
  endtask

  task automatic test_ovf_clr();
    reset_sync();
    for (int i = 1; i <= 5; i++) frame(4'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (OVF !== 1'b1) begin
      failures++; $display("FAIL clr_set got=%b exp=1", OVF);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (OVF !== 1'b0) begin
      failures++; $display("FAIL clr_pulse got=%b exp=0", OVF);
    end
    frame(4'd6, 1'b0, 1'b0, 1'b1);
    checks++;
    if (OVF !== 1'b1 || LEVEL !== 3'd4) begin
      failures++;
      $display("FAIL clr_vs_set got=%b/%0d exp=1/4", OVF, LEVEL);
    end
  endtask

  task automatic test_double_pulse();
    reset_sync();
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd1 || DOUT !== 4'd3) begin
      failures++;
      $display("FAIL double_pulse got=%0d/%0d exp=1/3", LEVEL, DOUT);
    end
  endtask

  task automatic test_reset_midframe();
    reset_sync();
    frame(4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd2) begin
      failures++; $display("FAIL mid_pre got=%0d exp=2", LEVEL);
    end
    RESET_N = 1'b0;
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd0 || DVALID !== 1'b0 || DOUT !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%b/%h exp=0/0/0", LEVEL, DVALID, DOUT);
    end
    RESET_N = 1'b1;
    frame(4'hC, 1'b0, 1'b0, 1'b0);
    checks++;
    if (DVALID !== 1'b0) begin
      failures++; $display("FAIL mid_ignored got=%b exp=0", DVALID);
    end
    frame(4'hD, 1'b0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd1 || DOUT !== 4'hD) begin
      failures++;
      $display("FAIL mid_recapture got=%0d/%h exp=1/d", LEVEL, DOUT);
    end
  endtask
`else
  task automatic test_avg();
    reset_sync();
    for (int i = 0; i < 3; i++) begin
      frame(4'd15, 1'b0, 1'b0, 1'b0);
      checks++;
      if (LEVEL !== 3'd0) begin
        failures++; $display("FAIL avg_partial%0d got=%0d exp=0", i, LEVEL);
      end
    end
    frame(4'd14, 1'b0, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd1 || DOUT !== 4'b1110) begin
      failures++;
      $display("FAIL avg_push got=%0d/%h exp=1/e", LEVEL, DOUT);
    end
  endtask
`endif

  task automatic test_random();
    int       pos;
    bit       ext;
    logic [3:0] exp_d;
    reset_sync();
    pos = 0;
    ext = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic sr;
      if (pos == 0) ext = ($urandom_range(0, 9) == 0);
      sr = (pos == 0) || (pos == 1 && ext) || ($urandom_range(0, 49) == 0);
      RESET_N = ($urandom_range(0, 199) != 0);
      step(sr, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 29) == 0));
      pos = (pos + 1) % 5;
      exp_d = (m_q.size() > 0) ? 4'(m_q[0]) : 4'd0;
      checks++;
      if (LEVEL !== 3'(m_q.size()) || DVALID !== (m_q.size() > 0) ||
          DOUT !== exp_d || OVF !== m_ovf) begin
        failures++;
        $display("FAIL random_cyc%0d got=%0d/%b/%h/%b exp=%0d/%b/%h/%b",
                 n, LEVEL, DVALID, DOUT, OVF,
                 m_q.size(), (m_q.size() > 0), exp_d, m_ovf);
      end
    end
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N   = 1'b0;
    SAR_RESET = 1'b0;
    BITS      = 3'd0;
    LSBIN     = 1'b0;
    DREADY    = 1'b0;
    OVF_CLR   = 1'b0;
    @(negedge CLK);
    test_reset();
`ifndef SAR_AVG_EN
    test_first_frame();
    test_overflow();
    test_full_pushpop();
    test_ovf_clr();
    test_double_pulse();
    test_reset_midframe();
`else
    test_avg();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sar_result_buffer.md
SAR_RESULT_BUFFER -- requirements
Module: sar_result_buffer

Interface
REQ-001 The block SHALL have the port CLK, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RESET_N, input, width 1: reset, synchronous and active-low.
REQ-003 The block SHALL have the port SAR_RESET, input, width 1: conversion-controller sample strobe, high for exactly one cycle per 5-cycle conversion frame.
REQ-004 The block SHALL have the port BITS, input, width 3: bit 3..bit 1 results held by the per-bit FSMs, valid while SAR_RESET is high.
REQ-005 The block SHALL have the port LSBIN, input, width 1: LSB result from the conversion controller, valid while SAR_RESET is high.
REQ-006 The block SHALL have the port DOUT, output, width 4: FIFO head code.
REQ-007 The block SHALL have the port DVALID, output, width 1: DOUT holds a valid code.
REQ-008 The block SHALL have the port DREADY, input, width 1: consumer accepts DOUT; a pop occurs on a cycle with DVALID && DREADY.
REQ-009 The block SHALL have the port OVF, output, width 1: sticky overflow flag.
REQ-010 The block SHALL have the port OVF_CLR, input, width 1: clears OVF.
REQ-011 The block SHALL have the port LEVEL, output, width 3: FIFO occupancy, 0..4.

Function
REQ-012 The capture FSM SHALL have the states IDLE and ARMED; on reset it SHALL be in IDLE.
REQ-013 In IDLE, a cycle with SAR_RESET=0 SHALL move the FSM to ARMED, so that the first SAR_RESET after reset, which carries no conversion data, is ignored.
REQ-014 In ARMED, a cycle with SAR_RESET=1 SHALL capture code = {BITS[2:0], LSBIN} and return the FSM to IDLE.
REQ-015 A SAR_RESET that stays high for two or more cycles SHALL produce only one capture.
REQ-016 Each capture SHALL produce a push, or a push candidate when SAR_AVG_EN is defined, which is written into the FIFO at the same clock edge.
REQ-017 Capture-to-output latency SHALL be 1 cycle: when the FIFO is empty, DVALID=1 and DOUT=code on the cycle after the capture edge.
REQ-018 The FIFO SHALL be 4 deep, first-in first-out, with pointers that wrap modulo 4.
REQ-019 LEVEL SHALL equal the number of stored codes.
REQ-020 DVALID SHALL equal (LEVEL != 0).
REQ-021 DOUT SHALL hold steady while DVALID && !DREADY.
REQ-022 When the FIFO is empty, DOUT SHALL read 4'b0000.
REQ-023 A push when LEVEL=4 with no simultaneous pop SHALL drop the code, leave the contents unchanged and set OVF.
REQ-024 A push and a pop on the same cycle when LEVEL=4 SHALL both take effect, with LEVEL staying at 4 and OVF unchanged.
REQ-025 A push and a pop on the same cycle when 0<LEVEL<4 SHALL leave LEVEL unchanged.
REQ-026 A pop when empty SHALL be ignored.
REQ-027 OVF_CLR=1 SHALL clear OVF on the next edge.
REQ-028 If OVF_CLR=1 coincides with a new overflow event, OVF SHALL end at 1 (set wins).

Reset
REQ-029 While RESET_N=0 at an edge, the FSM SHALL go to IDLE, the FIFO pointers and LEVEL SHALL go to 0, and OVF, DVALID and DOUT SHALL go to 0.
REQ-030 When SAR_AVG_EN is defined, reset SHALL also clear the averaging accumulator and the averaging count.
REQ-031 Reset asserted during a conversion frame SHALL discard any partial frame and partial average.
REQ-032 The first capture after reset release SHALL require a new SAR_RESET=0 cycle followed by a SAR_RESET=1 cycle.

Configuration
REQ-033 Macro SAR_AVG_EN defined: each capture SHALL add its code to a 6-bit accumulator and increment a 2-bit count.
REQ-034 Macro SAR_AVG_EN defined: on the 4th capture the block SHALL push (acc + code) >> 2, truncated to 4 bits, then clear the accumulator and the count.
REQ-035 Macro SAR_AVG_EN defined: a dropped averaged push SHALL set OVF.
REQ-036 Macro SAR_AVG_EN undefined: every capture SHALL push its code directly and no accumulator logic SHALL exist.

Structure
REQ-037 Package sar_pkg SHALL hold CODE_W=4, FIFO_DEPTH=4, AVG_N=4, LEVEL_W=3 and the capture-state enum {IDLE, ARMED}.
REQ-038 The storage SHALL be a sub-module sar_code_fifo that contains the pointers, LEVEL and the full/empty logic.
REQ-039 The capture FSM and the averaging logic SHALL sit in the top module.

Verification
REQ-040 Reset, then frames with BITS=3'b101 and LSBIN=1 -> first SAR_RESET ignored; the second frame gives DOUT=4'b1011 with DVALID=1 one cycle after the capture edge.
REQ-041 DREADY=0, 5 frames with codes 1,2,3,4,5 -> LEVEL=4 and OVF=1; then DREADY=1 -> outputs 1,2,3,4 in order, then DVALID=0.
REQ-042 LEVEL=4, DREADY=1 on the capture cycle of code 9 -> OVF stays 0, LEVEL=4, and 9 is the last code out.
REQ-043 OVF=1, then OVF_CLR pulse with no push -> OVF=0; OVF_CLR on the same cycle as an overflow -> OVF=1.
REQ-044 RESET_N=0 mid-frame with LEVEL=2 -> LEVEL=0, DVALID=0, DOUT=0; the next SAR_RESET is ignored.
REQ-045 SAR_AVG_EN defined, codes 15,15,15,14 -> one push of 4'b1110 (59>>2), and LEVEL=1 only after the 4th capture.
